// File: rtl/gray_bin_conv_pipe_if.sv
// Handshake bundle for gray_bin_conv_pipe: an input valid/ready channel
// carrying din/mode and an output valid/ready channel carrying dout.
// Build option GRAY_STEP_CHECK_EN adds the step_err/err_cnt status signals.
// slave  = the converter's view, master = the environment's view.
interface gray_bin_conv_pipe_if #(
    parameter int WIDTH = 4
`ifdef GRAY_STEP_CHECK_EN
    , parameter int ERRCNT_W = 8
`endif
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
`ifdef GRAY_STEP_CHECK_EN
    logic                step_err;
    logic [ERRCNT_W-1:0] err_cnt;
`endif

    modport slave (
        input  in_valid, mode, din, out_ready,
        output in_ready, out_valid, dout
`ifdef GRAY_STEP_CHECK_EN
        , output step_err, err_cnt
`endif
    );

    modport master (
        output in_valid, mode, din, out_ready,
        input  in_ready, out_valid, dout
`ifdef GRAY_STEP_CHECK_EN
        , input step_err, err_cnt
`endif
    );
endinterface

// File: rtl/gray_bin_conv_pipe.sv
// gray_bin_conv_pipe: one-entry, one-cycle-latency Gray<->binary converter
// with valid/ready flow control on both sides. mode=0 converts Gray to
// binary, mode=1 converts binary to Gray; mode travels with each word.
// Optional build macro GRAY_STEP_CHECK_EN adds a checker that flags
// consecutive Gray-mode inputs that do not differ in exactly one bit and
// keeps a saturating count of such step errors.
module gray_bin_conv_pipe #(
    parameter int WIDTH    = 4,
    parameter int ERRCNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    gray_bin_conv_pipe_if.slave bus
);

    // Elaboration-time parameter legality checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("gray_bin_conv_pipe: WIDTH must be in 2..32");
    end
    if (ERRCNT_W < 1 || ERRCNT_W > 16) begin : g_bad_errcnt_w
        $error("gray_bin_conv_pipe: ERRCNT_W must be in 1..16");
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: XOR with the logically right-shifted value.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic             vld_p0;
    logic [WIDTH-1:0] dout_p0;
    logic             accept;

    // A new word may enter whenever the output slot is empty or draining.
    assign bus.in_ready = !vld_p0 || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 0 register: load on accept, empty on transfer-only, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            dout_p0 <= '0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            dout_p0 <= bus.mode ? bin2gray(bus.din) : gray2bin(bus.din);
        end else if (bus.out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.dout      = dout_p0;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

    // True when exactly one bit of x is set.
    function automatic logic is_one_hot(input logic [WIDTH-1:0] x);
        return (x != '0) && ((x & (x - 1'b1)) == '0);
    endfunction

    logic [WIDTH-1:0]    hist_p0;
    logic                hist_vld_p0;
    logic                step_err_p0;
    logic [ERRCNT_W-1:0] err_cnt_p0;
    logic                bad_step;

    // A step is bad only when a previous Gray word exists to compare against.
    assign bad_step = hist_vld_p0 && !is_one_hot(bus.din ^ hist_p0);

    // Step checker: history and flag update only on accepted words, so the
    // flag stays aligned with the dout it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_p0     <= '0;
            hist_vld_p0 <= 1'b0;
            step_err_p0 <= 1'b0;
            err_cnt_p0  <= '0;
        end else if (accept) begin
            if (!bus.mode) begin
                hist_p0     <= bus.din;
                hist_vld_p0 <= 1'b1;
                step_err_p0 <= bad_step;
                if (bad_step && err_cnt_p0 != CNT_MAX) begin
                    err_cnt_p0 <= err_cnt_p0 + 1'b1;
                end
            end else begin
                step_err_p0 <= 1'b0;
            end
        end
    end

    assign bus.step_err = step_err_p0;
    assign bus.err_cnt  = err_cnt_p0;
`endif

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe (WIDTH=4). With GRAY_STEP_CHECK_EN
// defined it also exercises the step checker, including a second instance
// with a one-bit error counter to observe saturation.
module tb_gray_bin_conv_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       mode;
    logic [3:0] din;
    logic       out_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

`ifdef GRAY_STEP_CHECK_EN
    gray_bin_conv_pipe_if #(.WIDTH(4), .ERRCNT_W(8)) bus0 ();
    gray_bin_conv_pipe_if #(.WIDTH(4), .ERRCNT_W(1)) bus1 ();
`else
    gray_bin_conv_pipe_if #(.WIDTH(4)) bus0 ();
`endif

    assign bus0.in_valid  = in_valid;
    assign bus0.mode      = mode;
    assign bus0.din       = din;
    assign bus0.out_ready = out_ready;

    gray_bin_conv_pipe #(.WIDTH(4), .ERRCNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

`ifdef GRAY_STEP_CHECK_EN
    assign bus1.in_valid  = in_valid;
    assign bus1.mode      = mode;
    assign bus1.din       = din;
    assign bus1.out_ready = out_ready;

    gray_bin_conv_pipe #(.WIDTH(4), .ERRCNT_W(1)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; din = 4'b0000; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_dout",      32'(bus0.dout),      32'd0);
        chk("rst_in_ready",  32'(bus0.in_ready),  32'd1);

        // Continuous gray->binary flow
        in_valid = 1'b1; mode = 1'b0; din = 4'b1000;
        tick();
        chk("g2b_1000_dout", 32'(bus0.dout), 32'b1111);
        chk("g2b_1000_vld",  32'(bus0.out_valid), 32'd1);
        din = 4'b1001;
        tick();
        chk("g2b_1001_dout", 32'(bus0.dout), 32'b1110);
        chk("g2b_1001_vld",  32'(bus0.out_valid), 32'd1);
        din = 4'b1011;
        tick();
        chk("g2b_1011_dout", 32'(bus0.dout), 32'b1101);
        chk("g2b_1011_vld",  32'(bus0.out_valid), 32'd1);

        // Round trip with mixed modes
        mode = 1'b1; din = 4'b1101;
        tick();
        chk("b2g_1101_dout", 32'(bus0.dout), 32'b1011);
        mode = 1'b0; din = 4'b1011;
        tick();
        chk("rt_g2b_dout", 32'(bus0.dout), 32'b1101);

        // Drain, then stall with a held word
        in_valid = 1'b0;
        tick();
        chk("drain_vld", 32'(bus0.out_valid), 32'd0);
        chk("drain_dout_kept", 32'(bus0.dout), 32'b1101);
        in_valid = 1'b1; mode = 1'b0; din = 4'b0110; out_ready = 1'b0;
        tick();
        // Upstream offers another word that must be ignored during the stall
        din = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(bus0.in_ready),  32'd0);
            chk("stall_dout",     32'(bus0.dout),      32'b0100);
            chk("stall_vld",      32'(bus0.out_valid), 32'd1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus0.in_ready), 32'd1);
        tick();
        chk("release_vld",  32'(bus0.out_valid), 32'd0);
        chk("release_dout", 32'(bus0.dout),      32'b0100);

        // Reset while holding a stalled word, with a competing accept
        in_valid = 1'b1; mode = 1'b1; din = 4'b0011; out_ready = 1'b0;
        tick();
        chk("pre_rst_dout", 32'(bus0.dout), 32'b0010);
        rst = 1'b1; din = 4'b0101; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("mid_rst_vld",      32'(bus0.out_valid), 32'd0);
        chk("mid_rst_dout",     32'(bus0.dout),      32'd0);
        chk("mid_rst_in_ready", 32'(bus0.in_ready),  32'd1);

`ifdef GRAY_STEP_CHECK_EN
        chk("rst_step_err", 32'(bus0.step_err), 32'd0);
        chk("rst_err_cnt",  32'(bus0.err_cnt),  32'd0);
        out_ready = 1'b1; in_valid = 1'b1; mode = 1'b0;
        din = 4'b1000;
        tick();
        chk("sc_1000_err", 32'(bus0.step_err), 32'd0);
        din = 4'b1001;
        tick();
        chk("sc_1001_err", 32'(bus0.step_err), 32'd0);
        // A binary-mode word in between must not disturb the history
        mode = 1'b1; din = 4'b0000;
        tick();
        chk("sc_b2g_err", 32'(bus0.step_err), 32'd0);
        mode = 1'b0; din = 4'b1011;
        tick();
        chk("sc_1011_err", 32'(bus0.step_err), 32'd0);
        din = 4'b1110;
        tick();
        chk("sc_1110_err", 32'(bus0.step_err), 32'd1);
        chk("sc_1110_cnt", 32'(bus0.err_cnt),  32'd1);
        chk("sc_1110_dout", 32'(bus0.dout),    32'b1011);
        din = 4'b1000;
        tick();
        chk("sc_1000b_err",  32'(bus0.step_err), 32'd1);
        chk("sc_1000b_cnt",  32'(bus0.err_cnt),  32'd2);
        chk("sat_cnt_w1",    32'(bus1.err_cnt),  32'd1);
        in_valid = 1'b0;
        tick();
        chk("sc_hold_err", 32'(bus0.step_err), 32'd1);
        chk("sc_hold_vld", 32'(bus0.out_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net in case the sequence above ever stops advancing.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
